backing_line_memory: RTL and testbench

BACKING_LINE_MEMORY -- requirements
Module: backing_line_memory

---
 rtl/backing_line_memory.sv | 79 +++++++
 tb/tb_backing_line_memory.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/backing_line_memory.sv
// Line-wide backing store with fixed access latency: one request at a time,
// completion signalled by a single-cycle ack pulse.
module backing_line_memory #(
  parameter int LATENCY = 10,
  parameter int DEPTH   = 512
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  addr_i,
  input  logic [255:0] data_i,
  input  logic         enable_i,
  input  logic         write_i,
  output logic         ack_o,
  output logic [255:0] data_o
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t             state;
  logic [3:0]         cnt;
  logic [IDX_W-1:0]   idx_p0;
  logic [255:0]       line_p0;
  logic               write_p0;
  logic               done;
  logic [255:0]       mem [DEPTH];

  // Byte offset and address bits above the index play no part in the access.
  logic unused_addr;
  assign unused_addr = &{1'b0, addr_i[31:IDX_W+5], addr_i[4:0]};

  // Counter reads LATENCY-1 on the edge that is LATENCY edges after acceptance.
  assign done = (state == WAIT) && (cnt == 4'(LATENCY - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      ack_o  <= 1'b0;
      data_o <= '0;
      cnt    <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          ack_o <= 1'b0;
          if (enable_i) begin
            idx_p0   <= addr_i[IDX_W+4:5];
            line_p0  <= data_i;
            write_p0 <= write_i;
            cnt      <= 4'd0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt + 4'd1;
          if (done) begin
            state <= ACK;
            ack_o <= 1'b1;
            if (!write_p0) data_o <= mem[idx_p0];
          end
        end
        ACK: begin
          ack_o <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ack_o <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Array commit shares the ack edge; a reset on that edge abandons it.
  always_ff @(posedge clk_i) begin
    if (!rst_i && done && write_p0) mem[idx_p0] <= line_p0;
  end

endmodule

// File: tb/tb_backing_line_memory.sv
// Randomized and directed bench for backing_line_memory against an array-based
// reference model; instance 0 uses LATENCY=10, instance 1 uses LATENCY=2.
module tb_backing_line_memory;

  logic         clk = 1'b0;
  logic         rst;
  logic         en   [2];
  logic         we   [2];
  logic [31:0]  addr [2];
  logic [255:0] din  [2];
  logic         ack  [2];
  logic [255:0] dout [2];

  int checks   = 0;
  int failures = 0;

  logic [255:0] mem_m   [2][512];
  bit           written [2][512];
  logic [255:0] last_rd [2];

  always #5 clk = ~clk;

  backing_line_memory #(.LATENCY(10), .DEPTH(512)) dut0 (
    .clk_i(clk), .rst_i(rst), .addr_i(addr[0]), .data_i(din[0]),
    .enable_i(en[0]), .write_i(we[0]), .ack_o(ack[0]), .data_o(dout[0]));

  backing_line_memory #(.LATENCY(2), .DEPTH(512)) dut1 (
    .clk_i(clk), .rst_i(rst), .addr_i(addr[1]), .data_i(din[1]),
    .enable_i(en[1]), .write_i(we[1]), .ack_o(ack[1]), .data_o(dout[1]));

  function automatic int lat_of(input int s);
    return (s == 1) ? 2 : 10;
  endfunction

  function automatic int line_of(input logic [31:0] a);
    return int'((a / 32) % 512);
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after the accepting edge; waits for the ack and checks it.
  task automatic finish_txn(input int s, input bit w, input int idx, input logic [255:0] wd);
    int lat = 0;
    bit got = 0;
    while (lat < 40 && !got) begin
      @(posedge clk); #1;
      lat++;
      if (ack[s]) got = 1;
      else begin
        en[s] = 1'($urandom); we[s] = 1'($urandom);
        addr[s] = $urandom; din[s] = rnd256();
      end
    end
    en[s] = 1'b0;
    chk("ack_seen", 256'(got), 256'(1));
    if (got) begin
      chk("latency", 256'(lat), 256'(lat_of(s)));
      if (w) begin
        chk("wr_dout_hold", dout[s], last_rd[s]);
        mem_m[s][idx] = wd;
        written[s][idx] = 1;
      end else begin
        last_rd[s] = mem_m[s][idx];
        chk("rd_data", dout[s], last_rd[s]);
      end
      @(posedge clk); #1;
      chk("ack_width", 256'(ack[s]), 256'(0));
      chk("dout_after", dout[s], last_rd[s]);
    end
  endtask

  task automatic txn(input int s, input logic [31:0] a, input logic [255:0] d, input bit w);
    @(negedge clk);
    addr[s] = a; din[s] = d; we[s] = w; en[s] = 1'b1;
    @(posedge clk); #1;
    en[s] = 1'b0;
    finish_txn(s, w, line_of(a), d);
  endtask

  initial begin
    logic [255:0] v7, w7;
    int ack_edges [$];
    int edge_n;
    for (int s = 0; s < 2; s++) begin
      en[s] = 0; we[s] = 0; addr[s] = 0; din[s] = '0; last_rd[s] = '0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("rst_ack", 256'(ack[s]), 256'(0));
      chk("rst_dout", dout[s], '0);
    end
    @(negedge clk); rst = 1'b0;

    // Write all-A5 to 0x40, read back directly and through aliases.
    txn(0, 32'h0000_0040, {32{8'hA5}}, 1'b1);
    txn(0, 32'h0000_0040, '0, 1'b0);
    chk("a5_direct", dout[0], {32{8'hA5}});
    txn(0, 32'h0000_0045, '0, 1'b0);
    chk("a5_offset", dout[0], {32{8'hA5}});
    txn(0, 32'h0000_4040, '0, 1'b0);
    chk("a5_alias", dout[0], {32{8'hA5}});

    // Randomized traffic over a small line pool with aliasing upper bits.
    for (int i = 0; i < 24; i++) begin
      int s, idx;
      logic [31:0] a;
      bit w;
      s = (i % 4 == 3) ? 1 : 0;
      idx = $urandom_range(0, 7);
      a = ($urandom & 32'hFFFF_C000) | 32'(idx << 5) | 32'($urandom_range(0, 31));
      w = !written[s][idx] || ($urandom_range(0, 1) == 1);
      txn(s, a, rnd256(), w);
    end

    // Back-to-back reads with enable held high.
    @(negedge clk);
    addr[0] = 32'h0000_0040; we[0] = 1'b0; en[0] = 1'b1;
    edge_n = 0;
    while (edge_n < 80 && ack_edges.size() < 4) begin
      @(posedge clk); #1;
      edge_n++;
      if (ack[0]) begin
        ack_edges.push_back(edge_n);
        chk("stream_data", dout[0], mem_m[0][2]);
      end
    end
    en[0] = 1'b0;
    last_rd[0] = mem_m[0][2];
    chk("stream_count", 256'(ack_edges.size()), 256'(4));
    if (ack_edges.size() == 4) begin
      chk("stream_first", 256'(ack_edges[0]), 256'(11));
      for (int i = 1; i < 4; i++)
        chk("stream_spacing", 256'(ack_edges[i] - ack_edges[i-1]), 256'(12));
    end
    @(posedge clk); #1;
    chk("stream_ack_fall", 256'(ack[0]), 256'(0));

    // Reset in the middle of a write to index 7.
    v7 = rnd256();
    w7 = ~v7;
    txn(0, 32'h0000_00E0, v7, 1'b1);
    @(negedge clk);
    addr[0] = 32'h0000_00E0; din[0] = w7; we[0] = 1'b1; en[0] = 1'b1;
    @(posedge clk); #1;
    en[0] = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    last_rd[0] = '0; last_rd[1] = '0;
    chk("midrst_ack", 256'(ack[0]), 256'(0));
    chk("midrst_dout", dout[0], '0);
    @(negedge clk);
    addr[0] = 32'h0000_00E0; we[0] = 1'b0; en[0] = 1'b1;
    @(posedge clk); #1;
    chk("rst_en_ignored", 256'(ack[0]), 256'(0));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_no_ack", 256'(ack[0]), 256'(0));
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    en[0] = 1'b0;
    finish_txn(0, 1'b0, 7, '0);
    chk("idx7_kept", dout[0], v7);

    // Short-latency instance: single write then read.
    txn(1, 32'h0000_0100, {8{32'h1234_5678}}, 1'b1);
    txn(1, 32'h0000_0100, '0, 1'b0);
    chk("lat2_read", dout[1], {8{32'h1234_5678}});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
